ram_port_arbiter: RTL
=====================

Name: ram_port_arbiter

Overview:
- Shares the single 16x8 program/data RAM between two requesters: the CPU control path (fetch, indirect and operand reads, future stores) and a debug/loader port that preloads programs and inspects memory.
- Sits between the requesters and the RAM array. Each requester uses a req/ack handshake; the arbiter drives the RAM enable, write, address and data lines.
- Exposes `cpu_stall`, which freezes the sequence counter while a CPU access is outstanding.
- Round-robin arbitration; the CPU wins the first contested access after reset.

Parameters:
- AW, 4, address width (16 locations)
- DW, 8, data width
- ACC_LAT, 2, cycles `mem_en` is held per access; legal range 1..15 (0 is illegal)

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- cpu_req  in  1  CPU access request; held until cpu_ack
- cpu_we  in  1  1 = write, 0 = read
- cpu_addr  in  AW  CPU address
- cpu_wdata  in  DW  CPU write data
- cpu_ack  out  1  one-cycle completion pulse
- cpu_rdata  out  DW  registered read data for CPU
- dbg_req  in  1  debug access request; held until dbg_ack
- dbg_we  in  1  1 = write, 0 = read
- dbg_addr  in  AW  debug address
- dbg_wdata  in  DW  debug write data
- dbg_ack  out  1  one-cycle completion pulse
- dbg_rdata  out  DW  registered read data for debug
- mem_en  out  1  RAM access enable
- mem_we  out  1  RAM write strobe (valid only while mem_en=1)
- mem_addr  out  AW  RAM address
- mem_wdata  out  DW  RAM write data
- mem_rdata  in  DW  RAM read data, combinational from mem_addr
- cpu_stall  out  1  cpu_req & ~cpu_ack (combinational)
- busy  out  1  1 while state is not IDLE

Behaviour:
- Reset values: state=IDLE; mem_en=0; mem_we=0; mem_addr=0; mem_wdata=0; cpu_ack=0; dbg_ack=0; cpu_rdata=0; dbg_rdata=0; last_grant=DBG; cnt=0; busy=0.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - If neither request is high, stay in IDLE.
  - If exactly one request is high, grant it.
  - If both are high, grant the port that is not last_grant.
  - On grant: latch owner, we, addr and wdata from the winning port; set cnt=ACC_LAT-1; go to ACCESS.
- ACCESS:
  - mem_en=1; mem_we, mem_addr and mem_wdata come from the latched values only. Requester input changes are ignored.
  - While cnt≠0, decrement cnt.
  - When cnt=0 and the latched op is a read, register mem_rdata into the owner's rdata. Then go to RESP.
- RESP:
  - mem_en=0 and mem_we=0.
  - Owner's ack=1 for exactly this cycle; last_grant=owner.
  - Go to IDLE.
- Latency: a request sampled at edge k (in IDLE) gives ACCESS for cycles k+1..k+ACC_LAT and ack in cycle k+ACC_LAT+1. Throughput is one access per ACC_LAT+2 cycles.
- Handshake rules:
  - A requester holds req and its payload until it sees ack.
  - A req still high in IDLE after RESP counts as a new request. This allows back-to-back accesses; contested back-to-back accesses alternate between ports.
  - If req drops during ACCESS, the access still completes and ack is still pulsed (no abort).
- rdata: changes only when a read completes for that port. Writes and the other port's accesses leave it unchanged.
- Acks: cpu_ack and dbg_ack are never high in the same cycle. Neither ack fires without a preceding grant.
- Address and data widths are passed straight through; there is no arithmetic or wrap logic apart from cnt, which counts down from ACC_LAT-1 to 0 and never underflows.
- Reset mid-operation: rst has priority over all transitions. The next state is IDLE and all outputs take their reset values. An in-flight access is dropped with no ack; mem_we is low in the cycle after the rst edge.

Test Plan:
- CPU read, ACC_LAT=2, RAM[3]=0x76, cpu_req=1 addr=3 at edge 0 -> mem_en high cycles 1–2 with mem_addr=3, cpu_ack pulse in cycle 3, cpu_rdata=0x76, cpu_stall high cycles 0–2.
- Debug write addr=A data=0x5C, then CPU read addr=A -> mem_we=1 only during the debug ACCESS cycles, dbg_ack in cycle 3, cpu_rdata=0x5C, dbg_rdata still 0.
- cpu_req and dbg_req both held high from reset -> grant order CPU, DBG, CPU, DBG with acks 4 cycles apart, never simultaneous.
- Latched-payload stability: cpu_addr changes 3→7 in cycle 1 of an access -> mem_addr stays 3 and cpu_rdata=RAM[3].
- rst asserted in the 2nd ACCESS cycle of a debug write -> next cycle IDLE, mem_en=0, mem_we=0, no dbg_ack, rdata=0, next contested grant goes to CPU.
- ACC_LAT=1 build, single CPU read -> mem_en high 1 cycle, ack 2 cycles after req is sampled.

Source files
------------

// File: rtl/ram_port_arbiter.sv
// Purpose : round-robin arbiter sharing one AWxDW RAM between the CPU control path and a debug/loader port.
// Latency : request sampled in IDLE -> mem_en held ACC_LAT cycles -> one-cycle ack; one access per ACC_LAT+2 cycles.
// Backpressure: req/ack handshake; requester holds req+payload until ack, cpu_stall = cpu_req & ~cpu_ack.
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   cpu_req/we/addr/wdata -> ack, rdata   CPU requester (rdata updates only on CPU read completion)
//   dbg_req/we/addr/wdata -> ack, rdata   debug/loader requester (same rules)
//   mem_en/we/addr/wdata, mem_rdata       RAM side; mem_rdata is combinational from mem_addr
//   cpu_stall, busy                       CPU freeze request, FSM-not-idle flag
module ram_port_arbiter #(
  parameter int AW      = 4,
  parameter int DW      = 8,
  parameter int ACC_LAT = 2   // 1..15
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          dbg_req,
  input  logic          dbg_we,
  input  logic [AW-1:0] dbg_addr,
  input  logic [DW-1:0] dbg_wdata,
  output logic          dbg_ack,
  output logic [DW-1:0] dbg_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          cpu_stall,
  output logic          busy
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  localparam logic PORT_CPU = 1'b0;
  localparam logic PORT_DBG = 1'b1;

  localparam int            CW       = 4;
  localparam logic [CW-1:0] CNT_INIT = CW'(ACC_LAT - 1);

  state_t        state_q, state_d;
  logic          owner_q, owner_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          last_grant_q, last_grant_d;
  logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
  logic          grant_dbg;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      owner_q      <= PORT_CPU;
      we_q         <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt_q        <= '0;
      last_grant_q <= PORT_DBG;  // so the CPU wins the first contested access
      cpu_rdata_q  <= '0;
      dbg_rdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      we_q         <= we_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      cpu_rdata_q  <= cpu_rdata_d;
      dbg_rdata_q  <= dbg_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    we_d         = we_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    cpu_rdata_d  = cpu_rdata_q;
    dbg_rdata_d  = dbg_rdata_q;
    // Debug wins when it is alone, or when both ask and the CPU had the last turn.
    grant_dbg    = dbg_req && (!cpu_req || (last_grant_q == PORT_CPU));

    case (state_q)
      IDLE: begin
        if (cpu_req || dbg_req) begin
          owner_d = grant_dbg ? PORT_DBG : PORT_CPU;
          we_d    = grant_dbg ? dbg_we    : cpu_we;
          addr_d  = grant_dbg ? dbg_addr  : cpu_addr;
          wdata_d = grant_dbg ? dbg_wdata : cpu_wdata;
          cnt_d   = CNT_INIT;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else begin
          // Capture read data on the last enable cycle, into the owner's register only.
          if (!we_q) begin
            if (owner_q == PORT_DBG) dbg_rdata_d = mem_rdata;
            else                     cpu_rdata_d = mem_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        last_grant_d = owner_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // RAM side is driven purely from latched state, so requester changes mid-access are invisible.
  assign mem_en    = (state_q == ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign cpu_ack   = (state_q == RESP) && (owner_q == PORT_CPU);
  assign dbg_ack   = (state_q == RESP) && (owner_q == PORT_DBG);
  assign cpu_rdata = cpu_rdata_q;
  assign dbg_rdata = dbg_rdata_q;

  assign cpu_stall = cpu_req & ~cpu_ack;
  assign busy      = (state_q != IDLE);

endmodule
